// File: rtl/fu_pkg.sv
// Shared definitions for CDB-attached functional units.
// Op encodings, CDB entry layout and the add/sub op decoder.
package fu_pkg;

  localparam int OP_W = 2;

  localparam logic [OP_W-1:0] OP_ADD  = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB  = 2'b01;
  localparam logic [OP_W-1:0] OP_ADDS = 2'b10;
  localparam logic [OP_W-1:0] OP_SUBS = 2'b11;

  localparam int CDB_DATA_W = 16;
  localparam int CDB_TAG_W  = 3;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    logic                  ovf;
  } cdb_entry_t;

  typedef struct packed {
    logic sub;
    logic sat;
  } alu_ctl_t;

  function automatic alu_ctl_t decode_op(
    input logic [OP_W-1:0] op
  );
    alu_ctl_t c;
    c = '0;
    unique case (op)
      OP_ADD:  c = '{sub: 1'b0, sat: 1'b0};
      OP_SUB:  c = '{sub: 1'b1, sat: 1'b0};
      OP_ADDS: c = '{sub: 1'b0, sat: 1'b1};
      OP_SUBS: c = '{sub: 1'b1, sat: 1'b1};
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fu_result_fifo.sv
// In-order result buffer feeding the CDB.
// Head is visible combinationally; pointers wrap at DEPTH.
module fu_result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fu_adder_pipe.sv
// Pipelined integer add/sub unit with credit-based issue
// and an in-order result buffer arbitrated onto the CDB.
module fu_adder_pipe
  import fu_pkg::*;
#(
  parameter int WIDTH     = CDB_DATA_W,
  parameter int TAG_W     = CDB_TAG_W,
  parameter int LATENCY   = 2,
  parameter int OUT_DEPTH = 2
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [OP_W-1:0]  issue_op,
  input  logic [WIDTH-1:0] issue_a,
  input  logic [WIDTH-1:0] issue_b,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             cdb_req,
  input  logic             cdb_grant,
  output logic [WIDTH-1:0] cdb_data,
  output logic [TAG_W-1:0] cdb_tag,
  output logic             cdb_ovf
);

  localparam int EW = TAG_W + WIDTH + 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] data;
    logic             ovf;
  } ent_t;

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [CW-1:0]      credits;
  logic               accept;
  logic               pop;
  logic               fifo_empty;
  alu_ctl_t           ctl;
  logic [WIDTH-1:0]   sum;
  logic               sgn_a;
  logic               sgn_b;
  logic               ovf;
  ent_t               alu_ent;
  logic [LATENCY-1:0] s_vld;
  ent_t               s_ent [LATENCY];
  ent_t               head;
  logic [EW-1:0]      head_raw;

  // Credits cover every op from accept until its CDB pop,
  // so the buffer always has room for what is in flight.
  assign issue_ready = (credits < CW'(OUT_DEPTH));
  assign accept      = issue_valid && issue_ready && !flush;
  assign pop         = cdb_req && cdb_grant && !flush;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      credits <= '0;
    end else if (flush) begin
      credits <= '0;
    end else begin
      unique case ({accept, pop})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  always_comb begin
    ctl   = decode_op(issue_op);
    sum   = ctl.sub ? issue_a - issue_b
                    : issue_a + issue_b;
    sgn_a = issue_a[WIDTH-1];
    sgn_b = issue_b[WIDTH-1] ^ ctl.sub;
    ovf   = (sgn_a == sgn_b) &&
            (sum[WIDTH-1] != sgn_a);
    alu_ent      = '0;
    alu_ent.tag  = issue_tag;
    alu_ent.ovf  = ovf;
    alu_ent.data = sum;
    if (ctl.sat && ovf) begin
      alu_ent.data = sgn_a ? SMIN : SMAX;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      s_vld <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        s_ent[k] <= '0;
      end
    end else if (flush) begin
      s_vld <= '0;
    end else begin
      s_vld[0] <= accept;
      if (accept) begin
        s_ent[0] <= alu_ent;
      end
      for (int k = 1; k < LATENCY; k++) begin
        s_vld[k] <= s_vld[k-1];
        s_ent[k] <= s_ent[k-1];
      end
    end
  end

  fu_result_fifo #(
    .W     (EW),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk   (Clock),
    .rst_n (Resetn),
    .flush (flush),
    .push  (s_vld[LATENCY-1]),
    .din   (s_ent[LATENCY-1]),
    .pop   (pop),
    .dout  (head_raw),
    .empty (fifo_empty)
  );

  assign head     = ent_t'(head_raw);
  assign cdb_req  = !fifo_empty;
  assign cdb_data = head.data;
  assign cdb_tag  = head.tag;
  assign cdb_ovf  = head.ovf;

endmodule

// File: tb/tb_fu_adder_pipe.sv
// Bench for fu_adder_pipe: directed steps plus random
// streaming against a queue-based reference model.
module tb_fu_adder_pipe;
  import fu_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 2;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  issue_op;
  logic [15:0] issue_a;
  logic [15:0] issue_b;
  logic [2:0]  issue_tag;
  logic        cdb_req;
  logic        cdb_grant;
  logic [15:0] cdb_data;
  logic [2:0]  cdb_tag;
  logic        cdb_ovf;

  fu_adder_pipe #(
    .WIDTH     (16),
    .TAG_W     (3),
    .LATENCY   (LAT),
    .OUT_DEPTH (DEPTH)
  ) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_op    (issue_op),
    .issue_a     (issue_a),
    .issue_b     (issue_b),
    .issue_tag   (issue_tag),
    .cdb_req     (cdb_req),
    .cdb_grant   (cdb_grant),
    .cdb_data    (cdb_data),
    .cdb_tag     (cdb_tag),
    .cdb_ovf     (cdb_ovf)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [2:0]  tag;
    logic [15:0] data;
    logic        ovf;
    int          arr;
  } exp_t;

  exp_t q[$];
  int   edges  = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h exp %0h",
             tag, got, exp);
    end
  endtask

  function automatic void ref_alu(
    input  logic [1:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] r,
    output logic        o
  );
    int sa;
    int sb;
    int s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = (op == OP_SUB || op == OP_SUBS)
         ? sa - sb : sa + sb;
    o  = (s > 32767) || (s < -32768);
    r  = s[15:0];
    if ((op == OP_ADDS || op == OP_SUBS) && o)
      r = (sa < 0) ? 16'h8000 : 16'h7FFF;
  endfunction

  function automatic bit head_ready();
    return (q.size() > 0) && (q[0].arr <= edges);
  endfunction

  task automatic check_outs();
    bit rq;
    rq = head_ready();
    chk("ready", 32'(issue_ready),
        32'(q.size() < DEPTH));
    chk("req", 32'(cdb_req), 32'(rq));
    if (rq) begin
      chk("data", 32'(cdb_data), 32'(q[0].data));
      chk("tag",  32'(cdb_tag),  32'(q[0].tag));
      chk("ovf",  32'(cdb_ovf),  32'(q[0].ovf));
    end
  endtask

  task automatic step(input  logic        v,
                      input  logic [1:0]  op,
                      input  logic [15:0] a,
                      input  logic [15:0] b,
                      input  logic [2:0]  tag,
                      input  logic        g,
                      input  logic        f,
                      output bit          acc);
    bit   pp;
    exp_t e;
    issue_valid = v;
    issue_op    = op;
    issue_a     = a;
    issue_b     = b;
    issue_tag   = tag;
    cdb_grant   = g;
    flush       = f;
    acc = v && (q.size() < DEPTH) && !f;
    pp  = head_ready() && g && !f;
    @(posedge Clock);
    edges++;
    if (f) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        ref_alu(op, a, b, e.data, e.ovf);
        e.tag = tag;
        e.arr = edges + LAT;
        q.push_back(e);
      end
    end
    @(negedge Clock);
    check_outs();
  endtask

  task automatic idle(input logic g);
    bit acc;
    step(1'b0, 2'b00, 16'h0, 16'h0, 3'd0,
         g, 1'b0, acc);
  endtask

  task automatic expect_head(input logic [15:0] d,
                             input logic [2:0]  t,
                             input logic        o);
    chk("dir_req",  32'(cdb_req),  32'd1);
    chk("dir_data", 32'(cdb_data), 32'(d));
    chk("dir_tag",  32'(cdb_tag),  32'(t));
    chk("dir_ovf",  32'(cdb_ovf),  32'(o));
  endtask

  task automatic reset_check();
    chk("rst_ready", 32'(issue_ready), 32'd1);
    chk("rst_req",   32'(cdb_req),     32'd0);
    chk("rst_data",  32'(cdb_data),    32'd0);
    chk("rst_tag",   32'(cdb_tag),     32'd0);
    chk("rst_ovf",   32'(cdb_ovf),     32'd0);
  endtask

  logic [1:0]  dop [4];
  logic [15:0] da  [4];
  logic [15:0] db  [4];
  logic [15:0] dr  [4];
  logic        dov [4];

  initial begin
    bit acc;
    int got;
    int iter;
    Resetn      = 1'b0;
    flush       = 1'b0;
    issue_valid = 1'b0;
    issue_op    = 2'b00;
    issue_a     = 16'h0;
    issue_b     = 16'h0;
    issue_tag   = 3'd0;
    cdb_grant   = 1'b0;

    // reset held with random inputs
    repeat (4) begin
      @(negedge Clock);
      issue_valid = 1'($urandom);
      flush       = 1'($urandom);
      cdb_grant   = 1'($urandom);
      issue_op    = 2'($urandom);
      issue_a     = 16'($urandom);
      issue_b     = 16'($urandom);
      issue_tag   = 3'($urandom);
      #1;
      reset_check();
    end
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (3) idle(1'b0);

    // latency
    step(1'b1, OP_ADD, 16'h0003, 16'h0004,
         3'd5, 1'b1, 1'b0, acc);
    idle(1'b1);
    idle(1'b1);
    expect_head(16'h0007, 3'd5, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // arithmetic corners
    dop[0] = OP_ADD;  da[0] = 16'h7FFF; db[0] = 16'h0001;
    dr[0]  = 16'h8000; dov[0] = 1'b1;
    dop[1] = OP_ADDS; da[1] = 16'h7FFF; db[1] = 16'h0001;
    dr[1]  = 16'h7FFF; dov[1] = 1'b1;
    dop[2] = OP_SUBS; da[2] = 16'h8000; db[2] = 16'h0001;
    dr[2]  = 16'h8000; dov[2] = 1'b1;
    dop[3] = OP_SUB;  da[3] = 16'h0000; db[3] = 16'h0001;
    dr[3]  = 16'hFFFF; dov[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, dop[i], da[i], db[i], 3'(i + 1),
           1'b1, 1'b0, acc);
      idle(1'b1);
      idle(1'b1);
      expect_head(dr[i], 3'(i + 1), dov[i]);
      idle(1'b1);
    end

    // backpressure
    for (int i = 0; i < 5; i++) begin
      step(1'b1, OP_ADD, 16'(i * 3), 16'h0010,
           3'(i + 2), 1'b0, 1'b0, acc);
    end
    chk("bp_ready", 32'(issue_ready), 32'd0);
    chk("bp_req",   32'(cdb_req),     32'd1);
    chk("bp_tag0",  32'(cdb_tag),     32'd2);
    idle(1'b1);
    chk("bp_ready1", 32'(issue_ready), 32'd1);
    chk("bp_tag1",   32'(cdb_tag),     32'd3);
    repeat (4) idle(1'b1);

    // flush with ops in flight
    step(1'b1, OP_ADD, 16'h1111, 16'h1, 3'd6,
         1'b0, 1'b0, acc);
    step(1'b1, OP_SUB, 16'h2222, 16'h1, 3'd7,
         1'b0, 1'b0, acc);
    step(1'b1, OP_ADD, 16'h3333, 16'h1, 3'd2,
         1'b1, 1'b1, acc);
    chk("fl_ready", 32'(issue_ready), 32'd1);
    repeat (3) begin
      idle(1'b1);
      chk("fl_noreq", 32'(cdb_req), 32'd0);
    end
    step(1'b1, OP_ADD, 16'd10, 16'd20, 3'd3,
         1'b1, 1'b0, acc);
    idle(1'b1);
    idle(1'b1);
    expect_head(16'd30, 3'd3, 1'b0);
    idle(1'b1);

    // reset mid-operation
    step(1'b1, OP_ADD, 16'h0100, 16'h0001, 3'd4,
         1'b0, 1'b0, acc);
    step(1'b1, OP_ADD, 16'h0200, 16'h0001, 3'd5,
         1'b0, 1'b0, acc);
    idle(1'b0);
    Resetn = 1'b0;
    #1;
    reset_check();
    @(posedge Clock);
    edges++;
    @(negedge Clock);
    Resetn = 1'b1;
    q.delete();
    repeat (3) idle(1'b1);

    // random streaming
    got  = 0;
    iter = 0;
    while (got < 100 && iter < 2000) begin
      step(1'($urandom_range(0, 3) != 0),
           2'($urandom), 16'($urandom), 16'($urandom),
           3'($urandom), 1'($urandom), 1'b0, acc);
      if (acc) got++;
      iter++;
    end
    if (got < 100)
      chk("stream_bound", 32'(got), 32'd100);
    iter = 0;
    while (q.size() > 0 && iter < 50) begin
      idle(1'b1);
      iter++;
    end
    chk("drain_model", 32'(q.size()), 32'd0);
    chk("drain_req",   32'(cdb_req),  32'd0);
    chk("drain_ready", 32'(issue_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
